rc4_ksa_engine: RTL and testbench

//  Parametrised RC4 key-scheduling engine: optional identity fill s[i]=i, then the

---
 rtl/rc4_pkg.sv | 28 ++
 rtl/rc4_key_byte_mux.sv | 26 ++
 rtl/rc4_ksa_engine.sv | 146 ++++++++++++++
 tb/tb_rc4_ksa_engine.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 key-scheduling engine: state encoding and sizing limits.
package rc4_pkg;
  localparam int MAX_KEY_LENGTH = 32;
  localparam int MAX_RD_LATENCY = 3;
  localparam int KIDX_W = $clog2(MAX_KEY_LENGTH);

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_FILL    = 4'd1;
  localparam logic [3:0] ST_ISSUE_I = 4'd2;
  localparam logic [3:0] ST_WAIT_I  = 4'd3;
  localparam logic [3:0] ST_ISSUE_J = 4'd4;
  localparam logic [3:0] ST_WAIT_J  = 4'd5;
  localparam logic [3:0] ST_WR_J    = 4'd6;
  localparam logic [3:0] ST_WR_I    = 4'd7;
  localparam logic [3:0] ST_DONE    = 4'd8;

  typedef enum logic [3:0] {
    IDLE    = ST_IDLE,
    FILL    = ST_FILL,
    ISSUE_I = ST_ISSUE_I,
    WAIT_I  = ST_WAIT_I,
    ISSUE_J = ST_ISSUE_J,
    WAIT_J  = ST_WAIT_J,
    WR_J    = ST_WR_J,
    WR_I    = ST_WR_I,
    DONE    = ST_DONE
  } ksa_state_e;
endpackage

// File: rtl/rc4_key_byte_mux.sv
// Selects key byte kidx (byte 0 is the most significant) and fits it to the state width.
module rc4_key_byte_mux
  import rc4_pkg::*;
#(
  parameter int KEY_LENGTH = 3,
  parameter int STATE_W    = 8
) (
  input  logic [8*KEY_LENGTH-1:0] i_secret_key,
  input  logic [KIDX_W-1:0]       i_kidx,
  output logic [STATE_W-1:0]      o_key_byte
);
  logic [7:0] w_byte;

  always_comb begin
    w_byte = '0;
    for (int k = 0; k < KEY_LENGTH; k++) begin
      if (i_kidx == KIDX_W'(k)) w_byte = i_secret_key[8*(KEY_LENGTH-1-k) +: 8];
    end
  end

  if (STATE_W >= 8) begin : g_ext
    assign o_key_byte = STATE_W'(w_byte);
  end else begin : g_trunc
    assign o_key_byte = w_byte[STATE_W-1:0];
  end
endmodule

// File: rtl/rc4_ksa_engine.sv
// RC4 key scheduling over a single-port state RAM: optional identity fill, then the j-swap pass.
module rc4_ksa_engine
  import rc4_pkg::*;
#(
  parameter int KEY_LENGTH = 3,
  parameter int STATE_W    = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    do_init,
  input  logic [8*KEY_LENGTH-1:0] secret_key,
  output logic                    busy,
  output logic                    done,
  output logic [STATE_W-1:0]      address,
  output logic [STATE_W-1:0]      data,
  output logic                    wren,
  input  logic [STATE_W-1:0]      q
);
  logic [3:0]         r_state;
  logic [STATE_W-1:0] r_i;
  logic [STATE_W-1:0] r_j;
  logic [STATE_W-1:0] r_si;
  logic [STATE_W-1:0] r_sj;
  logic [KIDX_W-1:0]  r_kidx;
  logic [1:0]         r_wait;

  logic [STATE_W-1:0] w_key;
  logic [STATE_W-1:0] w_j_new;
  logic               w_last_wait;
  logic               w_i_last;
  logic               w_kidx_last;

  rc4_key_byte_mux #(.KEY_LENGTH(KEY_LENGTH), .STATE_W(STATE_W)) u_key_mux (
    .i_secret_key (secret_key),
    .i_kidx       (r_kidx),
    .o_key_byte   (w_key)
  );

  // j_new uses q directly so the ISSUE_J address is already valid on entry to that state
  assign w_j_new     = r_j + q + w_key;
  assign w_last_wait = (r_wait == 2'(RD_LATENCY - 1));
  assign w_i_last    = &r_i;
  assign w_kidx_last = (r_kidx == KIDX_W'(KEY_LENGTH - 1));

  // Outputs are loaded on the transition into the state that presents them
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      wren    <= 1'b0;
      address <= '0;
      data    <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_kidx  <= '0;
      r_wait  <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_i     <= '0;
            r_j     <= '0;
            r_kidx  <= '0;
            r_wait  <= '0;
            done    <= 1'b0;
            busy    <= 1'b1;
            address <= '0;
            data    <= '0;
            if (do_init) begin
              wren    <= 1'b1;
              r_state <= ST_FILL;
            end else begin
              r_state <= ST_ISSUE_I;
            end
          end
        end
        ST_FILL: begin
          if (w_i_last) begin
            r_i     <= '0;
            address <= '0;
            data    <= '0;
            wren    <= 1'b0;
            r_state <= ST_ISSUE_I;
          end else begin
            r_i     <= r_i + STATE_W'(1);
            address <= r_i + STATE_W'(1);
            data    <= r_i + STATE_W'(1);
          end
        end
        ST_ISSUE_I: begin
          r_wait  <= '0;
          r_state <= ST_WAIT_I;
        end
        ST_WAIT_I: begin
          if (w_last_wait) begin
            r_si    <= q;
            r_j     <= w_j_new;
            address <= w_j_new;
            r_state <= ST_ISSUE_J;
          end else begin
            r_wait <= r_wait + 2'd1;
          end
        end
        ST_ISSUE_J: begin
          r_wait  <= '0;
          r_state <= ST_WAIT_J;
        end
        ST_WAIT_J: begin
          if (w_last_wait) begin
            r_sj    <= q;
            address <= r_j;
            data    <= r_si;
            wren    <= 1'b1;
            r_state <= ST_WR_J;
          end else begin
            r_wait <= r_wait + 2'd1;
          end
        end
        ST_WR_J: begin
          address <= r_i;
          data    <= r_sj;
          r_state <= ST_WR_I;
        end
        ST_WR_I: begin
          wren <= 1'b0;
          data <= '0;
          if (w_i_last) begin
            address <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_i     <= r_i + STATE_W'(1);
            address <= r_i + STATE_W'(1);
            r_kidx  <= w_kidx_last ? '0 : r_kidx + KIDX_W'(1);
            r_state <= ST_ISSUE_I;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Bench: four engine configurations on behavioural latency RAMs, checked against a software KSA.
module tb_rc4_ksa_engine;
  import rc4_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [3:0]  start;
  logic [3:0]  do_init;
  logic [23:0] key0, key1;
  logic [7:0]  key2;
  logic [39:0] key3;
  logic [3:0]  busy, done, wren;
  logic [7:0]  addr [4];
  logic [7:0]  wdat [4];
  logic [7:0]  q    [4];

  rc4_ksa_engine #(.KEY_LENGTH(3), .STATE_W(8), .RD_LATENCY(1)) u0 (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .do_init(do_init[0]), .secret_key(key0),
    .busy(busy[0]), .done(done[0]), .address(addr[0]), .data(wdat[0]), .wren(wren[0]), .q(q[0]));
  rc4_ksa_engine #(.KEY_LENGTH(3), .STATE_W(8), .RD_LATENCY(2)) u1 (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .do_init(do_init[1]), .secret_key(key1),
    .busy(busy[1]), .done(done[1]), .address(addr[1]), .data(wdat[1]), .wren(wren[1]), .q(q[1]));
  rc4_ksa_engine #(.KEY_LENGTH(1), .STATE_W(8), .RD_LATENCY(1)) u2 (
    .clk(clk), .reset_n(reset_n), .start(start[2]), .do_init(do_init[2]), .secret_key(key2),
    .busy(busy[2]), .done(done[2]), .address(addr[2]), .data(wdat[2]), .wren(wren[2]), .q(q[2]));
  rc4_ksa_engine #(.KEY_LENGTH(5), .STATE_W(8), .RD_LATENCY(3)) u3 (
    .clk(clk), .reset_n(reset_n), .start(start[3]), .do_init(do_init[3]), .secret_key(key3),
    .busy(busy[3]), .done(done[3]), .address(addr[3]), .data(wdat[3]), .wren(wren[3]), .q(q[3]));

  // Behavioural single-port RAMs with a registered read pipeline per instance
  logic [7:0]  mem  [4][256];
  logic [7:0]  pipe [4][3];
  logic [15:0] wlog [$];

  always @(posedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (wren[g]) mem[g][addr[g]] <= wdat[g];
      pipe[g][0] <= mem[g][addr[g]];
      pipe[g][1] <= pipe[g][0];
      pipe[g][2] <= pipe[g][1];
    end
    if (wren[0]) wlog.push_back({addr[0], wdat[0]});
  end

  assign q[0] = pipe[0][0];
  assign q[1] = pipe[1][1];
  assign q[2] = pipe[2][0];
  assign q[3] = pipe[3][2];

  int klen [4] = '{3, 3, 1, 5};

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Reference: textbook RC4 KSA on a plain array
  logic [7:0] ref_s [256];
  logic [7:0] saved0 [256];

  task automatic model_ksa(input int kl, input logic [39:0] key, input bit init);
    int j;
    logic [7:0] t;
    if (init) for (int i = 0; i < 256; i++) ref_s[i] = 8'(i);
    j = 0;
    for (int i = 0; i < 256; i++) begin
      j = (j + int'(ref_s[i]) + int'(key[8*(kl-1-(i % kl)) +: 8])) % 256;
      t = ref_s[i];
      ref_s[i] = ref_s[j];
      ref_s[j] = t;
    end
  endtask

  task automatic set_key(input int g, input logic [39:0] k);
    case (g)
      0: key0 = k[23:0];
      1: key1 = k[23:0];
      2: key2 = k[7:0];
      default: key3 = k;
    endcase
  endtask

  task automatic run_one(input int g, input logic [39:0] key, input bit init,
                         input int exp_cyc, input bit pulse_mid);
    int cyc;
    int bad;
    bit zero_ok;
    logic [7:0] kb0;
    if (!init) for (int i = 0; i < 256; i++) ref_s[i] = mem[g][i];
    model_ksa(klen[g], key, init);
    set_key(g, key);
    if (g == 0) wlog.delete();
    @(negedge clk);
    start[g] = 1'b1;
    do_init[g] = init;
    @(negedge clk);
    start[g] = 1'b0;
    chk("busy_after_start", 32'(busy[g]), 1);
    chk("done_cleared", 32'(done[g]), 0);
    chk("first_address", 32'(addr[g]), 0);
    cyc = 0;
    zero_ok = 1'b1;
    while (busy[g] && cyc < 6000) begin
      if (!wren[g] && wdat[g] != 8'd0) zero_ok = 1'b0;
      cyc++;
      start[g] = (pulse_mid && cyc == 500);
      @(negedge clk);
    end
    start[g] = 1'b0;
    chk("busy_cycles", 32'(cyc), 32'(exp_cyc));
    chk("done_level", 32'(done[g]), 1);
    chk("wren_in_done", 32'(wren[g]), 0);
    chk("data_zero_when_idle", 32'(zero_ok), 1);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[g][i] !== ref_s[i]) bad++;
    chk("ram_vs_model_mismatches", 32'(bad), 0);
    if (g == 0 && init) begin
      kb0 = key[23:16];
      bad = 0;
      if (wlog.size() < 258) bad = 999;
      else for (int i = 0; i < 256; i++) if (wlog[i] !== {8'(i), 8'(i)}) bad++;
      chk("fill_writes_bad", 32'(bad), 0);
      if (wlog.size() >= 258) begin
        chk("first_swap_wr_j", 32'(wlog[256]), 32'({kb0, 8'd0}));
        chk("first_swap_wr_i", 32'(wlog[257]), 32'({8'd0, kb0}));
      end
    end
  endtask

  typedef struct {
    int          inst;
    logic [39:0] key;
    bit          init;
    int          exp_cyc;
    bit          pulse;
  } vec_t;

  vec_t vt [10];

  initial begin
    int n;
    int bad;
    reset_n = 1'b0;
    start   = '0;
    do_init = '0;
    key0 = '0; key1 = '0; key2 = '0; key3 = '0;

    vt[0] = '{0, 40'h0000010203, 1'b1, 1792, 1'b0};
    vt[1] = '{0, 40'h0000000000, 1'b1, 1792, 1'b0};
    vt[2] = '{0, 40'({$urandom(), $urandom()}), 1'b0, 1536, 1'b0};
    vt[3] = '{1, 40'h0000010203, 1'b1, 2304, 1'b0};
    vt[4] = '{2, 40'h00000000A5, 1'b1, 1792, 1'b0};
    vt[5] = '{2, 40'({$urandom(), $urandom()}), 1'b1, 1792, 1'b0};
    vt[6] = '{3, 40'h0102030405, 1'b1, 2816, 1'b0};
    vt[7] = '{3, 40'({$urandom(), $urandom()}), 1'b0, 2560, 1'b0};
    vt[8] = '{1, 40'({$urandom(), $urandom()}), 1'b1, 2304, 1'b0};
    vt[9] = '{0, 40'({$urandom(), $urandom()}), 1'b1, 1792, 1'b1};

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_wren", 32'(wren), 0);
    chk("reset_address", 32'(addr[0]), 0);
    chk("reset_data", 32'(wdat[0]), 0);

    for (int v = 0; v < 10; v++) begin
      run_one(vt[v].inst, vt[v].key, vt[v].init, vt[v].exp_cyc, vt[v].pulse);
      if (v == 0) for (int i = 0; i < 256; i++) saved0[i] = mem[0][i];
      if (v == 3) begin
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[1][i] !== saved0[i]) bad++;
        chk("lat2_equals_lat1_mismatches", 32'(bad), 0);
      end
    end

    // Reset pulse while instance 0 sits in WAIT_J of a shuffle
    set_key(0, 40'h0000112233);
    @(negedge clk);
    start[0] = 1'b1;
    do_init[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    n = 0;
    while (!(u0.r_state == ST_WAIT_J && n > 300) && n < 3000) begin
      n++;
      @(negedge clk);
    end
    chk("reached_wait_j", 32'(n < 3000), 1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("midreset_busy", 32'(busy[0]), 0);
    chk("midreset_wren", 32'(wren[0]), 0);
    chk("midreset_address", 32'(addr[0]), 0);
    chk("midreset_done", 32'(done[0]), 0);
    run_one(0, 40'h0000112233, 1'b1, 1792, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
